// File: rtl/segasys1_romarb.sv
// segasys1_romarb
//   Arbiter/sequencer for the single shared ROM store of the System 1 core
//   (main program, sound program, tile and sprite graphics). Serves three
//   read requesters (video, main CPU, sound CPU) plus the ROM download write
//   path, issuing one access at a time to a fixed-latency synchronous memory.
//
// Ports
//   CLK48M, RESETn          clock, async active-low reset
//   DLEN/DLWR/DLAD/DLDT     download bus (enable, write strobe, address, data)
//   DLOVF                   sticky: write strobe arrived while one was pending
//   vid_/cpu_/snd_ req,ad   level request + address, held until ack
//   vid_/cpu_/snd_ ack,dt   one-cycle done pulse + read data (held)
//   MEM_AD/MEM_RD/MEM_WE    memory address, read strobe, write strobe
//   MEM_DO/MEM_DI           memory write data / read data (MEM_LAT after RD)
module segasys1_romarb #(
  parameter int unsigned AW      = 18,
  parameter int unsigned MEM_LAT = 2,
  parameter int unsigned VID_MAX = 4
) (
  input  logic          CLK48M,
  input  logic          RESETn,
  input  logic          DLEN,
  input  logic          DLWR,
  input  logic [24:0]   DLAD,
  input  logic [7:0]    DLDT,
  output logic          DLOVF,
  input  logic          vid_req,
  input  logic [AW-1:0] vid_ad,
  output logic          vid_ack,
  output logic [7:0]    vid_dt,
  input  logic          cpu_req,
  input  logic [AW-1:0] cpu_ad,
  output logic          cpu_ack,
  output logic [7:0]    cpu_dt,
  input  logic          snd_req,
  input  logic [AW-1:0] snd_ad,
  output logic          snd_ack,
  output logic [7:0]    snd_dt,
  output logic [AW-1:0] MEM_AD,
  output logic          MEM_RD,
  output logic          MEM_WE,
  output logic [7:0]    MEM_DO,
  input  logic [7:0]    MEM_DI
);

  localparam int unsigned VCW = (VID_MAX < 1) ? 1 : $clog2(VID_MAX + 1);
  localparam logic [VCW-1:0] VID_MAX_V = VCW'(VID_MAX);
  // WAIT is entered on the MEM_RD cycle itself, so the counter starts one
  // above the memory latency; capture happens on the edge where it reads 1,
  // which is the edge that closes the cycle MEM_DI becomes valid.
  localparam logic [3:0] CNT_INIT = 4'(MEM_LAT + 1);

  typedef enum logic [0:0] {S_IDLE, S_WAIT} state_t;
  typedef enum logic [1:0] {P_VID, P_CPU, P_SND} port_t;

  state_t         state_q, state_d;
  port_t          port_q, port_d;
  logic [3:0]     cnt_q, cnt_d;
  logic           rr_q, rr_d;
  logic [VCW-1:0] vid_cnt_q, vid_cnt_d;

  logic           pend_q, pend_d;
  logic [AW-1:0]  pad_q, pad_d;
  logic [7:0]     pdt_q, pdt_d;
  logic           ovf_q, ovf_d;

  logic [AW-1:0]  mem_ad_q, mem_ad_d;
  logic           mem_rd_q, mem_rd_d;
  logic           mem_we_q, mem_we_d;
  logic [7:0]     mem_do_q, mem_do_d;

  logic           vid_ack_q, vid_ack_d;
  logic           cpu_ack_q, cpu_ack_d;
  logic           snd_ack_q, snd_ack_d;
  logic [7:0]     vid_dt_q, vid_dt_d;
  logic [7:0]     cpu_dt_q, cpu_dt_d;
  logic [7:0]     snd_dt_q, snd_dt_d;

  logic dl_hit;
  logic drain;
  logic other_req;
  logic gnt_vid, gnt_cpu, gnt_snd;

  // Download addresses beyond the store are silently dropped.
  assign dl_hit    = DLWR && ((DLAD >> AW) == '0);
  assign drain     = (state_q == S_IDLE) && pend_q;
  assign other_req = cpu_req || snd_req;

  // Video wins unless it has used up its burst allowance while CPU/sound wait.
  assign gnt_vid = vid_req && ((vid_cnt_q < VID_MAX_V) || !other_req);
  assign gnt_cpu = !gnt_vid && cpu_req && (!snd_req || !rr_q);
  assign gnt_snd = !gnt_vid && snd_req && !gnt_cpu;

  always_comb begin
    state_d   = state_q;
    port_d    = port_q;
    cnt_d     = cnt_q;
    rr_d      = rr_q;
    vid_cnt_d = vid_cnt_q;
    pend_d    = pend_q;
    pad_d     = pad_q;
    pdt_d     = pdt_q;
    ovf_d     = ovf_q;
    mem_ad_d  = mem_ad_q;
    mem_rd_d  = 1'b0;
    mem_we_d  = 1'b0;
    mem_do_d  = mem_do_q;
    vid_ack_d = 1'b0;
    cpu_ack_d = 1'b0;
    snd_ack_d = 1'b0;
    vid_dt_d  = vid_dt_q;
    cpu_dt_d  = cpu_dt_q;
    snd_dt_d  = snd_dt_q;

    case (state_q)
      S_IDLE: begin
        if (drain) begin
          mem_we_d = 1'b1;
          mem_ad_d = pad_q;
          mem_do_d = pdt_q;
        end else if (!DLEN && (gnt_vid || gnt_cpu || gnt_snd)) begin
          mem_rd_d = 1'b1;
          cnt_d    = CNT_INIT;
          state_d  = S_WAIT;
          if (gnt_vid) begin
            port_d   = P_VID;
            mem_ad_d = vid_ad;
            if (other_req && (vid_cnt_q < VID_MAX_V))
              vid_cnt_d = vid_cnt_q + 1'b1;
          end else if (gnt_cpu) begin
            port_d    = P_CPU;
            mem_ad_d  = cpu_ad;
            vid_cnt_d = '0;
            rr_d      = 1'b1;
          end else begin
            port_d    = P_SND;
            mem_ad_d  = snd_ad;
            vid_cnt_d = '0;
            rr_d      = 1'b0;
          end
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == 4'd1) begin
          state_d = S_IDLE;
          case (port_q)
            P_VID: begin
              vid_dt_d  = MEM_DI;
              vid_ack_d = 1'b1;
            end
            P_CPU: begin
              cpu_dt_d  = MEM_DI;
              cpu_ack_d = 1'b1;
            end
            default: begin
              snd_dt_d  = MEM_DI;
              snd_ack_d = 1'b1;
            end
          endcase
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Single-entry download buffer; a load in the drain cycle refills it
    // without counting as an overflow.
    if (drain)
      pend_d = 1'b0;
    if (dl_hit) begin
      if (pend_q && !drain)
        ovf_d = 1'b1;
      pend_d = 1'b1;
      pad_d  = DLAD[AW-1:0];
      pdt_d  = DLDT;
    end
  end

  always_ff @(posedge CLK48M or negedge RESETn) begin
    if (!RESETn) begin
      state_q   <= S_IDLE;
      port_q    <= P_VID;
      cnt_q     <= '0;
      rr_q      <= 1'b0;
      vid_cnt_q <= '0;
      pend_q    <= 1'b0;
      pad_q     <= '0;
      pdt_q     <= '0;
      ovf_q     <= 1'b0;
      mem_ad_q  <= '0;
      mem_rd_q  <= 1'b0;
      mem_we_q  <= 1'b0;
      mem_do_q  <= '0;
      vid_ack_q <= 1'b0;
      cpu_ack_q <= 1'b0;
      snd_ack_q <= 1'b0;
      vid_dt_q  <= '0;
      cpu_dt_q  <= '0;
      snd_dt_q  <= '0;
    end else begin
      state_q   <= state_d;
      port_q    <= port_d;
      cnt_q     <= cnt_d;
      rr_q      <= rr_d;
      vid_cnt_q <= vid_cnt_d;
      pend_q    <= pend_d;
      pad_q     <= pad_d;
      pdt_q     <= pdt_d;
      ovf_q     <= ovf_d;
      mem_ad_q  <= mem_ad_d;
      mem_rd_q  <= mem_rd_d;
      mem_we_q  <= mem_we_d;
      mem_do_q  <= mem_do_d;
      vid_ack_q <= vid_ack_d;
      cpu_ack_q <= cpu_ack_d;
      snd_ack_q <= snd_ack_d;
      vid_dt_q  <= vid_dt_d;
      cpu_dt_q  <= cpu_dt_d;
      snd_dt_q  <= snd_dt_d;
    end
  end

  assign DLOVF   = ovf_q;
  assign MEM_AD  = mem_ad_q;
  assign MEM_RD  = mem_rd_q;
  assign MEM_WE  = mem_we_q;
  assign MEM_DO  = mem_do_q;
  assign vid_ack = vid_ack_q;
  assign cpu_ack = cpu_ack_q;
  assign snd_ack = snd_ack_q;
  assign vid_dt  = vid_dt_q;
  assign cpu_dt  = cpu_dt_q;
  assign snd_dt  = snd_dt_q;

endmodule
